// File: rtl/key_input_pkg.sv
// Shared types and constants for the three-key debounce and event front end.
package key_input_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int unsigned KEY4     = 0;
    localparam int unsigned KEY5     = 1;
    localparam int unsigned KEY6     = 2;
    localparam int unsigned NUM_KEYS = 3;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Fixed priority: key4 over key5 over key6.
    function automatic logic [1:0] lowest_pending(input logic [2:0] p);
        if (p[KEY4]) return 2'(KEY4);
        if (p[KEY5]) return 2'(KEY5);
        if (p[KEY6]) return 2'(KEY6);
        return 2'd0;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: two-flop synchronizer, debounce FSM and auto-repeat timer.
module key_debounce
    import key_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC  = 20000,
    parameter int unsigned REPEAT_DELAY  = 500000,
    parameter int unsigned REPEAT_PERIOD = 100000
) (
    input  logic clk,
    input  logic nrst,
    input  logic raw,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int unsigned CNT_W = $clog2(max3(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CNT_W-1:0] DEB_M1 = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_M1 = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_M1 = CNT_W'(REPEAT_PERIOD - 1);

    logic [1:0]       sync_q;
    logic             s;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             in_period_q, in_period_d;
    logic             level_d, press_d, rel_d;
    logic [CNT_W-1:0] rep_limit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign s = sync_q[1];
    assign rep_limit = in_period_q ? PER_M1 : DLY_M1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q      <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            in_period_q <= 1'b0;
            level       <= 1'b0;
            press       <= 1'b0;
            rel         <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], raw};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            in_period_q <= in_period_d;
            level       <= level_d;
            press       <= press_d;
            rel         <= rel_d;
        end
    end

    // The sample that leaves IDLE/HELD counts as the first of the stable run.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rcnt_d      = rcnt_q;
        in_period_d = in_period_q;
        level_d     = level;
        press_d     = 1'b0;
        rel_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_M1) begin
                    state_d     = HELD;
                    cnt_d       = '0;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    rcnt_d      = '0;
                    in_period_d = 1'b0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end else if (!repeat_en) begin
                    rcnt_d      = '0;
                    in_period_d = 1'b0;
                end else if (rcnt_q >= rep_limit) begin
                    press_d     = 1'b1;
                    rcnt_d      = '0;
                    in_period_d = 1'b1;
                end else begin
                    rcnt_d = sat_inc(rcnt_q);
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    // Bounce back: repeat timing starts over from the initial delay.
                    state_d     = HELD;
                    cnt_d       = '0;
                    rcnt_d      = '0;
                    in_period_d = 1'b0;
                end else if (cnt_q >= DEB_M1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/key_input.sv
// Three debounced keys feeding a coalescing pending vector with fixed-priority event output.
module key_input
    import key_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC  = 20000,
    parameter int unsigned REPEAT_DELAY  = 500000,
    parameter int unsigned REPEAT_PERIOD = 100000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [2:0] key_raw,
    input  logic [2:0] repeat_en,
    output logic [2:0] key_level,
    output logic [2:0] key_press,
    output logic [2:0] key_release,
    output logic       evt_valid,
    output logic [1:0] evt_key,
    input  logic       evt_ack
);

    logic [2:0] pend_q, pend_d, clr;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_key (
            .clk      (clk),
            .nrst     (nrst),
            .raw      (key_raw[i]),
            .repeat_en(repeat_en[i]),
            .level    (key_level[i]),
            .press    (key_press[i]),
            .rel      (key_release[i])
        );
    end

    // A press landing on the acked key in the same cycle keeps its bit set.
    always_comb begin
        clr = '0;
        if (evt_ack && evt_valid) clr[evt_key] = 1'b1;
        pend_d = (pend_q & ~clr) | key_press;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pend_q    <= '0;
            evt_valid <= 1'b0;
            evt_key   <= '0;
        end else begin
            pend_q    <= pend_d;
            evt_valid <= |pend_d;
            evt_key   <= lowest_pending(pend_d);
        end
    end

endmodule

// File: tb/tb_key_input.sv
// Scoreboard bench for key_input: run-length reference model plus directed scenarios and random traffic.
module tb_key_input;

    localparam int DEB = 4;
    localparam int DLY = 20;
    localparam int PER = 8;

    typedef struct packed {
        logic [2:0] lvl;
        logic [2:0] prs;
        logic [2:0] rel;
        logic       vld;
        logic [1:0] key;
    } exp_t;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [2:0] key_raw = '0;
    logic [2:0] repeat_en = '0;
    logic       evt_ack = 1'b0;
    logic [2:0] key_level, key_press, key_release;
    logic       evt_valid;
    logic [1:0] evt_key;

    int checks = 0;
    int failures = 0;
    int rel_cnt[3];
    exp_t sb_q[$];

    key_input #(.DEBOUNCE_CYC(DEB), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .key_raw    (key_raw),
        .repeat_en  (repeat_en),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .evt_valid  (evt_valid),
        .evt_key    (evt_key),
        .evt_ack    (evt_ack)
    );

    always #5 clk = ~clk;

    // Reference model: a level change is accepted after DEB equal samples of the
    // synchronized input; repeats fire DLY, DLY+PER, ... held cycles after acceptance.
    int         m_run[3];
    int         m_age[3];
    bit         m_lvl[3], m_h1[3], m_h2[3];
    logic [2:0] m_pend, m_press_prev;

    always @(posedge clk) begin
        exp_t e;
        bit   d, done;
        e = '0;
        if (!nrst) begin
            for (int k = 0; k < 3; k++) begin
                m_run[k] = 0; m_age[k] = 0; m_lvl[k] = 0; m_h1[k] = 0; m_h2[k] = 0;
            end
            m_pend = '0;
            m_press_prev = '0;
        end else begin
            if (evt_ack && m_pend != 3'b000) begin
                done = 0;
                for (int k = 0; k < 3; k++)
                    if (!done && m_pend[k]) begin m_pend[k] = 1'b0; done = 1; end
            end
            m_pend = m_pend | m_press_prev;
            for (int k = 0; k < 3; k++) begin
                d = m_h2[k];
                m_h2[k] = m_h1[k];
                m_h1[k] = key_raw[k];
                if (!m_lvl[k]) begin
                    if (d) begin
                        m_run[k]++;
                        if (m_run[k] == DEB) begin
                            e.prs[k] = 1'b1; m_lvl[k] = 1; m_run[k] = 0; m_age[k] = 0;
                        end
                    end else m_run[k] = 0;
                end else if (!d) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        e.rel[k] = 1'b1; m_lvl[k] = 0; m_run[k] = 0;
                    end
                end else if (m_run[k] != 0) begin
                    m_run[k] = 0; m_age[k] = 0;
                end else if (!repeat_en[k]) begin
                    m_age[k] = 0;
                end else begin
                    m_age[k]++;
                    if (m_age[k] == DLY || (m_age[k] > DLY && (m_age[k] - DLY) % PER == 0))
                        e.prs[k] = 1'b1;
                end
                e.lvl[k] = m_lvl[k];
            end
            e.vld = |m_pend;
            for (int k = 2; k >= 0; k--) if (m_pend[k]) e.key = 2'(k);
            m_press_prev = e.prs;
        end
        sb_q.push_back(e);
    end

    // Monitor: compare every presented output cycle against the queued expectation.
    always @(negedge clk) begin
        exp_t e, a;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (!nrst) e = '0;
            a = {key_level, key_press, key_release, evt_valid, evt_key};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL scoreboard t=%0t got lvl=%b prs=%b rel=%b vld=%b key=%0d want lvl=%b prs=%b rel=%b vld=%b key=%0d",
                         $time, a.lvl, a.prs, a.rel, a.vld, a.key, e.lvl, e.prs, e.rel, e.vld, e.key);
            end
        end
        for (int k = 0; k < 3; k++) if (key_release[k] === 1'b1) rel_cnt[k]++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Ticks until the selected pulse is seen; got = ticks taken, -1 if the bound expires.
    task automatic wait_pulse(input bit is_rel, input int idx, input int limit, output int got);
        int i;
        i = 0;
        got = -1;
        while (got < 0 && i < limit) begin
            i++;
            tick();
            if ((is_rel ? key_release[idx] : key_press[idx]) === 1'b1) got = i;
        end
    endtask

    task automatic drain();
        evt_ack = 1'b1;
        repeat (5) tick();
        evt_ack = 1'b0;
    endtask

    int got, rel_before;

    initial begin
        tick();
        tick();
        check("reset_outputs", int'({key_level, key_press, key_release, evt_valid, evt_key}), 0);
        nrst = 1'b1;
        repeat (3) tick();

        // Short key6 pulse is rejected.
        key_raw = 3'b100;
        repeat (3) tick();
        key_raw = 3'b000;
        wait_pulse(0, 2, 15, got);
        check("short_pulse_no_press", got, -1);
        check("short_pulse_level", int'(key_level), 0);

        // Key5 single press, event presented and acked.
        key_raw = 3'b010;
        wait_pulse(0, 1, 12, got);
        check("key5_press_latency", got, 6);
        tick();
        check("key5_evt_valid", int'(evt_valid), 1);
        check("key5_evt_key", int'(evt_key), 1);
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        check("key5_ack_clears", int'(evt_valid), 0);
        tick();
        tick();
        key_raw = 3'b000;
        wait_pulse(1, 1, 12, got);
        check("key5_release_latency", got, 6);
        drain();

        // Key4 auto-repeat at 6, 26, 34, 42 then release.
        repeat_en = 3'b001;
        key_raw = 3'b001;
        wait_pulse(0, 0, 12, got);
        check("rep_first", got, 6);
        wait_pulse(0, 0, 30, got);
        check("rep_delay", got, 20);
        wait_pulse(0, 0, 15, got);
        check("rep_period1", got, 8);
        wait_pulse(0, 0, 15, got);
        check("rep_period2", got, 8);
        key_raw = 3'b000;
        wait_pulse(1, 0, 12, got);
        check("rep_release", got, 6);
        repeat_en = 3'b000;
        drain();

        // Key4 and key6 together: served lowest index first.
        key_raw = 3'b101;
        wait_pulse(0, 0, 12, got);
        check("dual_press_latency", got, 6);
        check("dual_press_vec", int'(key_press), 5);
        tick();
        check("dual_valid", int'(evt_valid), 1);
        check("dual_key_first", int'(evt_key), 0);
        evt_ack = 1'b1;
        tick();
        check("dual_key_second", int'(evt_key), 2);
        check("dual_valid_second", int'(evt_valid), 1);
        tick();
        evt_ack = 1'b0;
        check("dual_valid_empty", int'(evt_valid), 0);
        key_raw = 3'b000;
        repeat (10) tick();

        // One-cycle glitch while held restarts repeat timing, no release.
        repeat_en = 3'b001;
        key_raw = 3'b001;
        wait_pulse(0, 0, 12, got);
        check("glitch_press", got, 6);
        repeat (10) tick();
        rel_before = rel_cnt[0];
        key_raw = 3'b000;
        tick();
        key_raw = 3'b001;
        wait_pulse(0, 0, 40, got);
        check("glitch_repeat_restart", got, 23);
        check("glitch_no_release", rel_cnt[0], rel_before);
        check("glitch_level", int'(key_level[0]), 1);
        key_raw = 3'b000;
        repeat_en = 3'b000;
        repeat (10) tick();
        drain();

        // Reset while key5 held; held key is debounced afresh afterwards.
        key_raw = 3'b010;
        wait_pulse(0, 1, 12, got);
        check("rst_pre_press", got, 6);
        repeat (3) tick();
        nrst = 1'b0;
        #1;
        check("rst_outputs_zero", int'({key_level, key_press, key_release, evt_valid, evt_key}), 0);
        tick();
        tick();
        check("rst_outputs_hold", int'({key_level, key_press, key_release, evt_valid, evt_key}), 0);
        nrst = 1'b1;
        wait_pulse(0, 1, 12, got);
        check("rst_new_press", got, 6);
        key_raw = 3'b000;
        repeat (10) tick();
        drain();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 29) == 0) key_raw[k] = ~key_raw[k];
            if ($urandom_range(0, 59) == 0) repeat_en = 3'($urandom_range(0, 7));
            evt_ack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) nrst = 1'b0;
            else if (!nrst && $urandom_range(0, 1) == 0) nrst = 1'b1;
        end
        nrst = 1'b1;
        key_raw = '0;
        evt_ack = 1'b0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_input.md
KEY_INPUT -- requirements
Module: key_input

Interface
REQ-001 The block SHALL have the parameter DEBOUNCE_CYC, default 20000: consecutive stable cycles required to accept a level change.
REQ-002 The block SHALL have the parameter REPEAT_DELAY, default 500000: cycles a key must be held before the first auto-repeat press.
REQ-003 The block SHALL have the parameter REPEAT_PERIOD, default 100000: cycles between later auto-repeat presses.
REQ-004 The block SHALL have the port clk, input, width 1: single clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port nrst, input, width 1: asynchronous active-low reset.
REQ-006 The block SHALL have the port key_raw, input, width 3: raw pushbuttons, active-high and asynchronous; bit 0 = key4, bit 1 = key5, bit 2 = key6.
REQ-007 The block SHALL have the port repeat_en, input, width 3: per-key auto-repeat enable.
REQ-008 The block SHALL have the port key_level, output, width 3: debounced key state.
REQ-009 The block SHALL have the port key_press, output, width 3: one-cycle pulse per accepted press or repeat.
REQ-010 The block SHALL have the port key_release, output, width 3: one-cycle pulse per accepted release.
REQ-011 The block SHALL have the port evt_valid, output, width 1: a key event is pending.
REQ-012 The block SHALL have the port evt_key, output, width 2: index (0..2) of the presented event; valid only while evt_valid is high.
REQ-013 The block SHALL have the port evt_ack, input, width 1: consumer accepts the presented event.

Function
REQ-014 Each key_raw bit SHALL pass through a two-flop synchronizer before any other use.
REQ-015 Each key SHALL have an FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-016 IDLE SHALL go to PRESS_WAIT when the synchronized input is 1; PRESS_WAIT SHALL return to IDLE if the input is 0 before DEBOUNCE_CYC consecutive 1 samples.
REQ-017 After DEBOUNCE_CYC consecutive 1 samples in PRESS_WAIT, the FSM SHALL enter HELD, set key_level, and pulse key_press in the same cycle.
REQ-018 HELD SHALL go to RELEASE_WAIT on a synchronized 0; RELEASE_WAIT SHALL return to HELD on a 1 before DEBOUNCE_CYC consecutive 0 samples, otherwise go to IDLE, clear key_level, and pulse key_release.
REQ-019 In HELD with repeat_en set, key_press SHALL pulse REPEAT_DELAY cycles after entering HELD and then every REPEAT_PERIOD cycles.
REQ-020 A return from RELEASE_WAIT to HELD SHALL restart the repeat timing from REPEAT_DELAY.
REQ-021 When repeat_en is low, the repeat counter SHALL hold at zero and no repeat pulses SHALL occur.
REQ-022 Counters SHALL be sized with $clog2 of the largest parameter plus 1, and SHALL saturate rather than wrap.
REQ-023 The block SHALL hold a 3-bit pending vector; a key_press pulse SHALL set its bit, and a press on an already-pending key SHALL coalesce with no overflow indication.
REQ-024 evt_valid SHALL equal OR(pending), and evt_key SHALL be the lowest-index pending bit (fixed priority key4 > key5 > key6).
REQ-025 When evt_ack and evt_valid are both high, the bit at evt_key SHALL clear at the next edge and the next pending key SHALL be presented in the following cycle.
REQ-026 When evt_ack is high while evt_valid is low, the ack SHALL be ignored.
REQ-027 When evt_ack and a new press of the same key occur in the same cycle, the bit SHALL remain set.
REQ-028 Simultaneous presses of several keys SHALL set all of their bits in one cycle.
REQ-029 Latency from a stable key_raw edge to key_press SHALL be 2 + DEBOUNCE_CYC cycles.

Reset
REQ-030 While nrst = 0, all FSMs SHALL be in IDLE, the synchronizers, counters and pending vector SHALL be 0, and key_level, key_press, key_release, evt_valid and evt_key SHALL be 0.
REQ-031 When reset is asserted mid-debounce or mid-hold, the press in progress SHALL be discarded, and a key held through reset release SHALL be debounced afresh as a new press.

Structure
REQ-032 A shared package SHALL hold the FSM state typedef and the key index constants KEY4 = 0, KEY5 = 1 and KEY6 = 2.
REQ-033 A sub-module key_debounce SHALL contain the synchronizer, FSM and counters for one key, and key_input SHALL instantiate it three times and add the pending/event logic.

Verification
REQ-034 Bench parameters SHALL be DEBOUNCE_CYC = 4, REPEAT_DELAY = 20 and REPEAT_PERIOD = 8.
REQ-035 The bench SHALL cover: key6 high for 3 cycles, then low -> no key_press and key_level stays 0.
REQ-036 The bench SHALL cover: key5 held for 10 cycles with repeat_en = 0 -> one key_press[1] exactly 6 cycles after the edge, evt_key = 1, and evt_ack clears evt_valid on the next cycle.
REQ-037 The bench SHALL cover: key4 held with repeat_en[0] = 1 -> key_press[0] at cycles 6, 26, 34 and 42 after the edge, and release gives key_release[0] 6 cycles after the falling edge.
REQ-038 The bench SHALL cover: key4 and key6 pressed in the same cycle -> pending = 101, evt_key = 0 then 2 on successive acks, then evt_valid = 0.
REQ-039 The bench SHALL cover: a 1-cycle glitch to 0 during HELD -> no key_release, and the repeat timing restarts.
REQ-040 The bench SHALL cover: nrst pulsed low while key5 is in HELD -> all outputs 0 during reset, and a new key_press[1] 6 cycles after release of reset.
